// File: rtl/chrono_if.sv
// chrono_if: key inputs, live count and sequencer outputs of the stopwatch.
// slave = chrono_ctrl side, master = key/counter side.
interface chrono_if #(
  parameter int CW = 17
);
  logic          key_ss;
  logic          key_lr;
  logic [CW-1:0] count_in;
  logic          run;
  logic          clr;
  logic          freeze;
  logic [CW-1:0] disp;
  logic [1:0]    state_o;

  modport master (
    output key_ss, key_lr, count_in,
    input  run, clr, freeze, disp, state_o
  );

  modport slave (
    input  key_ss, key_lr, count_in,
    output run, clr, freeze, disp, state_o
  );
endinterface

// File: rtl/chrono_ctrl.sv
// chrono_ctrl: stopwatch key sequencer (sync, debounce, start/stop/lap/clear FSM).
// Ports: clk, rst (async active-low), bus (chrono_if.slave: key_ss, key_lr,
// count_in in; run, clr, freeze, disp, state_o out).
// Optional macro CHRONO_AUTOSTOP_EN: stop when count_in hits MAX_COUNT.
module chrono_deb #(
  parameter int DEB_CYCLES     = 250000,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic settled,
  output logic press
);
  localparam int CNTW = $clog2(DEB_CYCLES);
  localparam logic [CNTW-1:0] LAST = CNTW'(DEB_CYCLES - 1);
  localparam logic REL = (BTN_ACTIVE_LOW != 0);

  logic s1, s2;
  logic lvl;
  logic deb, deb_q;
  logic armed;
  logic [CNTW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= REL;
      s2 <= REL;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

  assign lvl = s2 ^ REL;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (lvl != deb) begin
      if (cnt == LAST) begin
        deb <= lvl;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // armed only after a released level is seen once the synchroniser
  // has flushed, so a key held through reset never fires
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      deb_q <= deb;
      armed <= armed | (settled & ~lvl & ~deb);
    end
  end

  assign press = deb & ~deb_q & armed;
endmodule

module chrono_ctrl #(
  parameter int DEB_CYCLES     = 250000,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int CW             = 17,
  parameter int MAX_COUNT      = 99999
) (
  input  logic     clk,
  input  logic     rst,
  chrono_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } st_t;

`ifdef CHRONO_AUTOSTOP_EN
  localparam bit AUTOSTOP = 1'b1;
`else
  localparam bit AUTOSTOP = 1'b0;
`endif

  st_t state, state_nx;
  logic [1:0] settle;
  logic settled;
  logic ss, lr;
  logic at_max;
  logic lap_load;
  logic clr_nx;
  logic freeze_nx;
  logic clr_q;
  logic [CW-1:0] lap_reg;
  logic [CW-1:0] disp_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle <= 2'd0;
    end else if (settle != 2'd2) begin
      settle <= settle + 2'd1;
    end
  end

  assign settled = (settle == 2'd2);

  chrono_deb #(
    .DEB_CYCLES     (DEB_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_deb_ss (
    .clk     (clk),
    .rst     (rst),
    .key     (bus.key_ss),
    .settled (settled),
    .press   (ss)
  );

  chrono_deb #(
    .DEB_CYCLES     (DEB_CYCLES),
    .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
  ) u_deb_lr (
    .clk     (clk),
    .rst     (rst),
    .key     (bus.key_lr),
    .settled (settled),
    .press   (lr)
  );

  assign at_max = AUTOSTOP &&
                  (bus.count_in == CW'(MAX_COUNT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ss always beats lr; the losing lr press is simply dropped
  always_comb begin
    state_nx = state;
    lap_load = 1'b0;
    clr_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss) state_nx = RUN;
      end
      RUN: begin
        if (at_max || ss) begin
          state_nx = STOP;
        end else if (lr) begin
          state_nx = LAP;
          lap_load = 1'b1;
        end
      end
      LAP: begin
        if (at_max || ss) begin
          state_nx = STOP;
        end else if (lr) begin
          state_nx = RUN;
        end
      end
      STOP: begin
        if (ss) begin
          state_nx = RUN;
        end else if (lr) begin
          state_nx = IDLE;
          clr_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign freeze_nx = (state_nx == LAP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_reg <= '0;
      clr_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      if (lap_load) lap_reg <= bus.count_in;
      clr_q <= clr_nx;
      // on the capture edge the snapshot equals count_in anyway
      disp_q <= (freeze_nx && !lap_load) ? lap_reg
                                         : bus.count_in;
    end
  end

  always_comb begin
    bus.run     = (state == RUN) || (state == LAP);
    bus.freeze  = (state == LAP);
    bus.state_o = state;
    bus.clr     = clr_q;
    bus.disp    = disp_q;
  end
endmodule

// File: tb/tb_chrono_ctrl.sv
// tb_chrono_ctrl: directed scoreboard bench for chrono_ctrl
// (DEB_CYCLES=4, active-low keys, CW=17, MAX_COUNT=50).
module tb_chrono_ctrl;
  localparam int CW = 17;
  localparam logic PR = 1'b0;
  localparam logic RL = 1'b1;
  localparam int S_ST   = 0;
  localparam int S_RUN  = 1;
  localparam int S_CLR  = 2;
  localparam int S_FRZ  = 3;
  localparam int S_DISP = 4;
  localparam int S_CNT  = 5;
  localparam int S_LAP  = 6;
  localparam int IDLE = 0;
  localparam int RUN  = 1;
  localparam int LAP  = 2;
  localparam int STOP = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int checks = 0;
  int errors = 0;
  int cnt_obs;
  logic [1:0] prev;
  exp_t sbq[$];

  chrono_if #(.CW(CW)) bus ();

  chrono_ctrl #(
    .DEB_CYCLES     (4),
    .BTN_ACTIVE_LOW (1),
    .CW             (CW),
    .MAX_COUNT      (50)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] obs(int sel);
    case (sel)
      S_ST:   return {30'd0, bus.state_o};
      S_RUN:  return {31'd0, bus.run};
      S_CLR:  return {31'd0, bus.clr};
      S_FRZ:  return {31'd0, bus.freeze};
      S_DISP: return {15'd0, bus.disp};
      S_CNT:  return cnt_obs;
      S_LAP:  return {15'd0, dut.lap_reg};
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic push(string tag, int sel, int v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d",
               e.tag, o, e.val);
      end
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    bus.key_ss = RL;
    bus.key_lr = RL;
    bus.count_in = '0;
    cyc(2);
    push("rst_state", S_ST, IDLE);
    push("rst_run", S_RUN, 0);
    push("rst_clr", S_CLR, 0);
    push("rst_freeze", S_FRZ, 0);
    push("rst_disp", S_DISP, 0);
    drain();
    rst = 1'b1;
    cyc(3);

    // 3-cycle glitch is rejected
    bus.key_ss = PR;
    cyc(3);
    bus.key_ss = RL;
    cyc(10);
    push("glitch_state", S_ST, IDLE);
    drain();

    // clean press, DEB_CYCLES+3 latency
    bus.count_in = 100;
    bus.key_ss = PR;
    cyc(6);
    push("lat_pre_state", S_ST, IDLE);
    push("lat_pre_run", S_RUN, 0);
    drain();
    cyc(1);
    push("lat_state", S_ST, RUN);
    push("lat_run", S_RUN, 1);
    push("lat_disp", S_DISP, 100);
    drain();
    bus.key_ss = RL;
    cyc(8);

    // lap capture and hold
    bus.count_in = 1234;
    bus.key_lr = PR;
    cyc(7);
    push("lap_state", S_ST, LAP);
    push("lap_freeze", S_FRZ, 1);
    push("lap_run", S_RUN, 1);
    push("lap_disp", S_DISP, 1234);
    drain();
    bus.count_in = 1300;
    cyc(2);
    push("lap_hold_disp", S_DISP, 1234);
    drain();
    bus.key_lr = RL;
    cyc(8);
    bus.key_lr = PR;
    cyc(7);
    push("unlap_state", S_ST, RUN);
    push("unlap_freeze", S_FRZ, 0);
    push("unlap_disp", S_DISP, 1300);
    drain();
    bus.key_lr = RL;
    cyc(8);

    // stop shows live count
    bus.count_in = 2000;
    bus.key_ss = PR;
    cyc(7);
    push("stop_state", S_ST, STOP);
    push("stop_run", S_RUN, 0);
    push("stop_disp", S_DISP, 2000);
    drain();
    bus.count_in = 2001;
    cyc(1);
    push("stop_live_disp", S_DISP, 2001);
    drain();
    bus.key_ss = RL;
    cyc(8);

    // clear pulse on STOP -> IDLE
    bus.key_lr = PR;
    cyc(6);
    push("clr_pre", S_CLR, 0);
    push("clr_pre_state", S_ST, STOP);
    drain();
    cyc(1);
    push("clr_state", S_ST, IDLE);
    push("clr_pulse", S_CLR, 1);
    drain();
    cyc(1);
    push("clr_one_cycle", S_CLR, 0);
    drain();
    bus.key_lr = RL;
    cyc(8);

    // presses in IDLE never pulse clr
    cnt_obs = 0;
    bus.key_lr = PR;
    repeat (10) begin
      cyc(1);
      if (bus.clr) cnt_obs++;
    end
    bus.key_lr = RL;
    repeat (10) begin
      cyc(1);
      if (bus.clr) cnt_obs++;
    end
    push("idle_lr_noclr", S_CNT, 0);
    push("idle_lr_state", S_ST, IDLE);
    drain();
    cnt_obs = 0;
    bus.key_ss = PR;
    repeat (10) begin
      cyc(1);
      if (bus.clr) cnt_obs++;
    end
    bus.key_ss = RL;
    repeat (10) begin
      cyc(1);
      if (bus.clr) cnt_obs++;
    end
    push("idle_ss_noclr", S_CNT, 0);
    push("idle_ss_state", S_ST, RUN);
    drain();

    // simultaneous ss+lr: ss wins, no capture
    bus.count_in = 3000;
    bus.key_ss = PR;
    bus.key_lr = PR;
    cyc(7);
    push("simul_state", S_ST, STOP);
    push("simul_freeze", S_FRZ, 0);
    push("simul_disp", S_DISP, 3000);
    push("simul_lap", S_LAP, 1234);
    drain();
    bus.key_ss = RL;
    bus.key_lr = RL;
    cyc(8);

    // held key gives a single transition
    cnt_obs = 0;
    prev = bus.state_o;
    bus.key_ss = PR;
    repeat (100) begin
      cyc(1);
      if (bus.state_o !== prev) cnt_obs++;
      prev = bus.state_o;
    end
    bus.key_ss = RL;
    cyc(8);
    push("hold_transitions", S_CNT, 1);
    push("hold_state", S_ST, RUN);
    drain();

    // terminal count
    bus.count_in = 49;
    cyc(1);
    bus.count_in = 50;
    cyc(1);
`ifdef CHRONO_AUTOSTOP_EN
    push("max_state", S_ST, STOP);
    push("max_run", S_RUN, 0);
`else
    push("max_state", S_ST, RUN);
    push("max_run", S_RUN, 1);
`endif
    drain();
    bus.count_in = 60;
    cyc(2);
`ifdef CHRONO_AUTOSTOP_EN
    bus.key_ss = PR;
    cyc(7);
    bus.key_ss = RL;
    cyc(8);
`endif

    // reset mid-LAP with ss held through reset
    bus.count_in = 70;
    bus.key_lr = PR;
    cyc(7);
    push("pre_rst_state", S_ST, LAP);
    push("pre_rst_freeze", S_FRZ, 1);
    drain();
    bus.key_lr = RL;
    cyc(8);
    bus.key_ss = PR;
    cyc(2);
    #2 rst = 1'b0;
    #1;
    push("mid_rst_state", S_ST, IDLE);
    push("mid_rst_run", S_RUN, 0);
    push("mid_rst_freeze", S_FRZ, 0);
    push("mid_rst_clr", S_CLR, 0);
    push("mid_rst_disp", S_DISP, 0);
    drain();
    cyc(3);
    rst = 1'b1;
    cyc(20);
    push("held_rst_state", S_ST, IDLE);
    push("held_rst_clr", S_CLR, 0);
    drain();
    bus.key_ss = RL;
    cyc(8);
    bus.key_ss = PR;
    cyc(7);
    push("repress_state", S_ST, RUN);
    push("repress_run", S_RUN, 1);
    drain();
    bus.key_ss = RL;
    cyc(8);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
